// File: rtl/uart_rx.sv
// uart_rx: 8N1-style asynchronous serial receiver.
//   Samples each bit at its mid-point using a bit-time counter of
//   T = CLKS_PER_SAMPLE*SAMPLES_PER_BIT clocks. Received words are
//   presented on data_bus with a valid/acknowledge handshake. Framing
//   errors (stop bit 0) and overruns (unread word overwritten) are
//   flagged.
// Ports:
//   clk           - system clock, rising edge
//   rst_b         - synchronous reset, active low
//   serial_in     - asynchronous serial line, idles high
//   read_ack      - single-cycle pulse: consumer has taken data_bus
//   data_bus      - last successfully received word
//   byte_valid    - data_bus holds an unread word
//   framing_error - last frame had a stop bit of 0
//   overrun_error - an unread word was overwritten (sticky until read_ack)
module uart_rx #(
    parameter int unsigned WORD_SIZE       = 8,
    parameter int unsigned CLKS_PER_SAMPLE = 4,
    parameter int unsigned SAMPLES_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 serial_in,
    input  logic                 read_ack,
    output logic [WORD_SIZE-1:0] data_bus,
    output logic                 byte_valid,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int unsigned BIT_T  = CLKS_PER_SAMPLE * SAMPLES_PER_BIT;
    localparam int unsigned HALF_T = BIT_T / 2;
    localparam int unsigned CNT_W  = (BIT_T > 1) ? $clog2(BIT_T) : 1;
    localparam int unsigned IDX_W  = $clog2(WORD_SIZE + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_T - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_T - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state, state_next;
    logic                 sync_1, rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [WORD_SIZE-1:0] shreg;

    logic tick;
    logic shift_en;
    logic load_good;
    logic set_fe;

    // The counter is cleared on the detection cycle, so the value
    // HALF_T-1 recurs exactly at D+T/2+k*T, i.e. every bit mid-point.
    assign tick = (cnt == CNT_MID);

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        load_good  = 1'b0;
        set_fe     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (tick) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) state_next = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        load_good  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        set_fe     = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_1        <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            data_bus      <= '0;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            sync_1 <= serial_in;
            rx_s   <= sync_1;
            state  <= state_next;

            if (state == IDLE || state == WAIT_HIGH) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            // First received bit ends up in bit 0 after WORD_SIZE shifts.
            if (shift_en) shreg <= {rx_s, shreg[WORD_SIZE-1:1]};

            if (load_good) begin
                data_bus      <= shreg;
                byte_valid    <= 1'b1;
                framing_error <= 1'b0;
                // An ack in the load cycle consumes the old word, so no overrun.
                if (byte_valid && !read_ack) begin
                    overrun_error <= 1'b1;
                end else if (byte_valid && read_ack) begin
                    overrun_error <= 1'b0;
                end
            end else if (read_ack && byte_valid) begin
                byte_valid    <= 1'b0;
                overrun_error <= 1'b0;
            end

            if (set_fe) framing_error <= 1'b1;
        end
    end

endmodule
